// File: rtl/drp_reg_slave_if.sv
// DRP bus between a DRP master and drp_reg_slave, plus the fabric-side
// write-commit strobe group.
interface drp_reg_slave_if #(
  parameter int ADDR_WIDTH = 10
) ();
  logic [ADDR_WIDTH-1:0] drp_addr;
  logic [15:0]           drp_di;
  logic [15:0]           drp_do;
  logic                  drp_en;
  logic                  drp_we;
  logic                  drp_rdy;
  logic                  drp_err;
  logic                  wr_strobe;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_data;

  modport slave (
    input  drp_addr, drp_di, drp_en, drp_we,
    output drp_do, drp_rdy, drp_err, wr_strobe, wr_addr, wr_data
  );

  modport master (
    output drp_addr, drp_di, drp_en, drp_we,
    input  drp_do, drp_rdy, drp_err, wr_strobe, wr_addr, wr_data
  );
endinterface

// File: rtl/drp_reg_slave.sv
// DRP responder backed by a 16-bit register array, with write-commit strobes.
// Optional macro DRP_REG_SLAVE_LFSR_LATENCY_EN adds 0..3 pseudo-random wait cycles per transaction.
module drp_reg_slave #(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 64,
  parameter int RDY_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst,
  drp_reg_slave_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [15:0]           di_q, di_d;
  logic                  we_q, we_d;
  logic [15:0]           do_q, do_d;
  logic                  err_q, err_d;
  logic                  strb_q, strb_d;
  logic [ADDR_WIDTH-1:0] wa_q, wa_d;
  logic [15:0]           wd_q, wd_d;
  logic [15:0]           mem_q [DEPTH];
  logic [4:0]            extra;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  function automatic logic [IDX_W-1:0] idx(input logic [ADDR_WIDTH-1:0] a);
    return a[IDX_W-1:0];
  endfunction

`ifdef DRP_REG_SLAVE_LFSR_LATENCY_EN
  logic [7:0] lfsr_q, lfsr_d;
  assign extra = {3'b000, lfsr_q[1:0]};
`else
  assign extra = 5'd0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    di_d    = di_q;
    we_d    = we_q;
    do_d    = 16'h0000;
    err_d   = 1'b0;
    strb_d  = 1'b0;
    wa_d    = wa_q;
    wd_d    = wd_q;
`ifdef DRP_REG_SLAVE_LFSR_LATENCY_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.drp_en) begin
          addr_d  = bus.drp_addr;
          di_d    = bus.drp_di;
          we_d    = bus.drp_we;
          cnt_d   = 5'(RDY_LATENCY - 1) + extra;
          state_d = (cnt_d == 5'd0) ? RESP : WAIT;
`ifdef DRP_REG_SLAVE_LFSR_LATENCY_EN
          // x^8+x^6+x^5+x^4+1, shifting toward the MSB
          lfsr_d  = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
`endif
        end
      end
      WAIT: begin
        err_d = bus.drp_en;
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) state_d = RESP;
      end
      RESP: begin
        err_d   = bus.drp_en;
        state_d = IDLE;
        // Out-of-range writes still strobe so the fabric sees every commit attempt.
        if (we_q) begin
          strb_d = 1'b1;
          wa_d   = addr_q;
          wd_d   = di_q;
        end
      end
      default: state_d = IDLE;
    endcase
    // Read data is fetched on entry to RESP so drp_do is registered alongside drp_rdy.
    if (state_d == RESP && !we_d && in_range(addr_d)) do_d = mem_q[idx(addr_d)];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      addr_q  <= '0;
      di_q    <= 16'h0000;
      we_q    <= 1'b0;
      do_q    <= 16'h0000;
      err_q   <= 1'b0;
      strb_q  <= 1'b0;
      wa_q    <= '0;
      wd_q    <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      di_q    <= di_d;
      we_q    <= we_d;
      do_q    <= do_d;
      err_q   <= err_d;
      strb_q  <= strb_d;
      wa_q    <= wa_d;
      wd_q    <= wd_d;
      if (state_q == RESP && we_q && in_range(addr_q)) mem_q[idx(addr_q)] <= di_q;
    end
  end

`ifdef DRP_REG_SLAVE_LFSR_LATENCY_EN
  always_ff @(posedge clk) begin
    if (rst) lfsr_q <= 8'h01;
    else     lfsr_q <= lfsr_d;
  end
`endif

  assign bus.drp_rdy   = (state_q == RESP);
  assign bus.drp_do    = do_q;
  assign bus.drp_err   = err_q;
  assign bus.wr_strobe = strb_q;
  assign bus.wr_addr   = wa_q;
  assign bus.wr_data   = wd_q;

endmodule

// File: tb/tb_drp_reg_slave.sv
// Directed bench for drp_reg_slave: vector table of DRP transactions plus
// hand-written busy-error and mid-transaction reset sequences.
module tb_drp_reg_slave;
  localparam int AW    = 10;
  localparam int DEPTH = 64;
`ifdef DRP_REG_SLAVE_LFSR_LATENCY_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  drp_reg_slave_if #(.ADDR_WIDTH(AW)) bus ();

  drp_reg_slave #(.ADDR_WIDTH(AW), .DEPTH(DEPTH), .RDY_LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [15:0]   di;
    logic [15:0]   exp_do;
  } vec_t;

  vec_t       tbl [14];
  int         total = 0;
  int         bad   = 0;
  logic [7:0] lfsr_m;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Expected latency of the next accepted transaction.
  task automatic take_lat(output int lat);
    lat = LAT;
`ifdef DRP_REG_SLAVE_LFSR_LATENCY_EN
    lat = LAT + int'(lfsr_m[1:0]);
    lfsr_m = {lfsr_m[6:0], lfsr_m[7] ^ lfsr_m[5] ^ lfsr_m[4] ^ lfsr_m[3]};
`endif
  endtask

  task automatic idle_inputs();
    bus.drp_en   = 1'b0;
    bus.drp_we   = 1'b0;
    bus.drp_addr = '0;
    bus.drp_di   = 16'h0000;
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] addr, input logic [15:0] di);
    bus.drp_en   = 1'b1;
    bus.drp_we   = we;
    bus.drp_addr = addr;
    bus.drp_di   = di;
  endtask

  // Issue at the current negedge; returns at the negedge after the strobe cycle check.
  task automatic run_txn(input string name, input logic we, input logic [AW-1:0] addr,
                         input logic [15:0] di, input logic [15:0] exp_do);
    int lat, seen, rdys, nz;
    logic [15:0] got;
    take_lat(lat);
    drive(we, addr, di);
    seen = -1; rdys = 0; nz = 0; got = 16'h0000;
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (k == 1) idle_inputs();
      if (bus.drp_rdy === 1'b1) begin
        rdys++;
        if (seen < 0) begin seen = k; got = bus.drp_do; end
      end else if (bus.drp_do !== 16'h0000) nz++;
      if (bus.wr_strobe !== 1'b0) nz++;
    end
    check({name, ".lat"}, seen, lat);
    check({name, ".rdys"}, rdys, 1);
    check({name, ".do"}, got, we ? 16'h0000 : exp_do);
    @(negedge clk);
    if (bus.drp_rdy !== 1'b0 || bus.drp_do !== 16'h0000) nz++;
    check({name, ".quiet"}, nz, 0);
    check({name, ".strobe"}, bus.wr_strobe, we);
    if (we) begin
      check({name, ".wa"}, bus.wr_addr, addr);
      check({name, ".wd"}, bus.wr_data, di);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, rdys, strb, seen;
    logic [15:0] got;

    tbl[0]  = '{1'b1, 10'h005, 16'hBEEF, 16'h0000};
    tbl[1]  = '{1'b0, 10'h005, 16'h0000, 16'hBEEF};
    tbl[2]  = '{1'b0, 10'h040, 16'h0000, 16'h0000};
    tbl[3]  = '{1'b1, 10'h040, 16'h1234, 16'h0000};
    tbl[4]  = '{1'b0, 10'h000, 16'h0000, 16'h0000};
    tbl[5]  = '{1'b1, 10'h03F, 16'hFFFF, 16'h0000};
    tbl[6]  = '{1'b0, 10'h03F, 16'h0000, 16'hFFFF};
    tbl[7]  = '{1'b1, 10'h000, 16'h1357, 16'h0000};
    tbl[8]  = '{1'b0, 10'h000, 16'h0000, 16'h1357};
    tbl[9]  = '{1'b0, 10'h005, 16'h0000, 16'hBEEF};
    tbl[10] = '{1'b1, 10'h005, 16'h0001, 16'h0000};
    tbl[11] = '{1'b0, 10'h005, 16'h0000, 16'h0001};
    tbl[12] = '{1'b0, 10'h3FF, 16'h0000, 16'h0000};
    tbl[13] = '{1'b0, 10'h03F, 16'h0000, 16'hFFFF};

    idle_inputs();
    rst = 1'b1;
    lfsr_m = 8'h01;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst.rdy", bus.drp_rdy, 0);
    check("rst.err", bus.drp_err, 0);
    check("rst.strobe", bus.wr_strobe, 0);
    check("rst.do", bus.drp_do, 0);
    check("rst.wa", bus.wr_addr, 0);
    check("rst.wd", bus.wr_data, 0);

    // drp_we/addr/di wiggling without drp_en must do nothing
    bus.drp_we = 1'b1; bus.drp_addr = 10'h005; bus.drp_di = 16'hFFFF;
    rdys = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.drp_rdy !== 1'b0 || bus.wr_strobe !== 1'b0 || bus.drp_err !== 1'b0) rdys++;
    end
    check("noen.quiet", rdys, 0);
    idle_inputs();

    for (int i = 0; i < 14; i++)
      run_txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].di, tbl[i].exp_do);

    // Second request one cycle after the first: ignored, err flagged.
    take_lat(lat);
    drive(1'b0, 10'h005, 16'h0000);
    rdys = 0; strb = 0; seen = -1; got = 16'h0000;
    for (int k = 1; k <= lat + 3; k++) begin
      @(negedge clk);
      if (k == 1) drive(1'b1, 10'h005, 16'hDEAD);
      else idle_inputs();
      if (bus.drp_rdy === 1'b1) begin
        rdys++;
        if (seen < 0) begin seen = k; got = bus.drp_do; end
      end
      if (bus.wr_strobe !== 1'b0) strb++;
      if (k == 2) check("busy.err", bus.drp_err, 1);
      if (k == 3) check("busy.err_clr", bus.drp_err, 0);
    end
    check("busy.rdys", rdys, 1);
    check("busy.lat", seen, lat);
    check("busy.do", got, 16'h0001);
    check("busy.strobe", strb, 0);
    run_txn("busy.reread", 1'b0, 10'h005, 16'h0000, 16'h0001);

    // Request during the drp_rdy cycle itself.
    take_lat(lat);
    drive(1'b0, 10'h000, 16'h0000);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      idle_inputs();
      if (k == lat) begin
        check("rdyhit.rdy", bus.drp_rdy, 1);
        drive(1'b1, 10'h000, 16'hFFFF);
      end
    end
    @(negedge clk);
    idle_inputs();
    check("rdyhit.err", bus.drp_err, 1);
    rdys = 0;
    repeat (6) begin
      if (bus.drp_rdy !== 1'b0 || bus.wr_strobe !== 1'b0) rdys++;
      @(negedge clk);
    end
    check("rdyhit.ignored", rdys, 0);
    run_txn("rdyhit.reread", 1'b0, 10'h000, 16'h0000, 16'h1357);

    // Reset while a write is waiting.
    take_lat(lat);
    drive(1'b1, 10'h003, 16'hAAAA);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lfsr_m = 8'h01;
    rdys = 0;
    repeat (5) begin
      if (bus.drp_rdy !== 1'b0 || bus.wr_strobe !== 1'b0 || bus.drp_do !== 16'h0000) rdys++;
      @(negedge clk);
    end
    check("rstmid.quiet", rdys, 0);
    run_txn("rstmid.rd3", 1'b0, 10'h003, 16'h0000, 16'h0000);
    run_txn("rstmid.rd5", 1'b0, 10'h005, 16'h0000, 16'h0000);
    run_txn("rstmid.rd0", 1'b0, 10'h000, 16'h0000, 16'h0000);

    // Eight back-to-back reads from a fresh reset.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    lfsr_m = 8'h01;
    run_txn("b2b.wr", 1'b1, 10'h007, 16'h5A5A, 16'h0000);
    for (int i = 0; i < 8; i++)
      run_txn($sformatf("b2b.rd%0d", i), 1'b0, 10'h007, 16'h0000, 16'h5A5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
